dfg_seq_ctrl: RTL and testbench
===============================

DFG_SEQ_CTRL -- requirements
Module: dfg_seq_ctrl

Interface
REQ-001 Parameter ADWIDTH, default 16: instruction address and DFG length width.
REQ-002 Parameter CWIDTH, default 8: DFG count width.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Group_Start  input  1  single-cycle request to run one group.
REQ-006 Abort  input  1  level; terminates a running group.
REQ-007 DFG_Num  input  CWIDTH  number of DFGs in the group; sampled on accepted start.
REQ-008 DFG_Len  input  ADWIDTH  cycles per DFG; sampled on accepted start.
REQ-009 Inst_Addr  output  ADWIDTH  address into the push/pop schedule ROM.
REQ-010 Inst_Data  input  4  ROM word {Push1,Pop1,Push0,Pop0}; valid one cycle after Inst_Addr.
REQ-011 DBuf0_Status, DBuf1_Status  output  2  each; 00 group done/idle, 01 computing, 10 DFG done (final), 11 jump to next DFG.
REQ-012 DBuf0_Push, DBuf0_Pop, DBuf1_Push, DBuf1_Pop  output  1  each; per-cycle buffer commands.
REQ-013 Busy  output  1  high in any state other than IDLE.
REQ-014 Group_Done  output  1  single-cycle pulse when a group completes normally.

Function
REQ-015 States: IDLE, LOAD, RUN, NEXT, DONE; registered state, one transition per cycle max.
REQ-016 IDLE: statuses 00; Group_Start=1 with DFG_Num!=0 and DFG_Len!=0 latches both, clears Inst_Addr to 0, clears DFG and cycle counters, enters LOAD.
REQ-017 Group_Start with DFG_Num==0 or DFG_Len==0 ignored; Group_Start outside IDLE ignored.
REQ-018 LOAD: one cycle, statuses 00, Inst_Addr increments; next state RUN.
REQ-019 RUN: statuses 01 for exactly DFG_Len consecutive cycles per DFG; Inst_Addr increments every RUN cycle; cycle counter increments.
REQ-020 On last RUN cycle of a DFG: if DFG counter+1 < DFG_Num, go NEXT; else go DONE.
REQ-021 NEXT: one cycle, statuses 11, Inst_Addr held, DFG counter increments, cycle counter cleared; next state RUN.
REQ-022 DONE: one cycle, statuses 10, Group_Done=1 in that cycle; next state IDLE.
REQ-023 Push/pop outputs equal corresponding Inst_Data bits in RUN cycles only; forced 0 in all other states.
REQ-024 Consequence of REQ-018/019/021: RUN cycle k of the group (k counted across DFGs from 0) drives ROM word k.
REQ-025 DBuf0_Status and DBuf1_Status always identical.
REQ-026 Inst_Addr wraps modulo 2^ADWIDTH without error.
REQ-027 Abort=1 in LOAD, RUN, NEXT or DONE: next cycle IDLE, statuses 00, push/pop 0, no Group_Done; Abort has priority over all transitions; Abort in IDLE has no effect and does not block Group_Start.
REQ-028 DFG_Num/DFG_Len changes during a group do not affect it.

Reset
REQ-029 Reset=1 at any edge, including mid-group: state IDLE, Inst_Addr 0, counters 0, statuses 00, push/pop 0, Busy 0, Group_Done 0; Reset overrides Abort and Group_Start.

Verification
REQ-030 DFG_Num=2, DFG_Len=3, start -> status 00(LOAD),01,01,01,11,01,01,01,10,00; Busy high 9 cycles; Group_Done one pulse coincident with 10.
REQ-031 ROM word k = k[3:0], same config -> push/pop per RUN cycle = words 0,1,2,3,4,5 in order; all 0 in LOAD/NEXT/DONE.
REQ-032 Start with DFG_Num=0 or DFG_Len=0 -> Busy stays 0, statuses stay 00; second Group_Start during RUN -> no effect on sequence.
REQ-033 DFG_Num=1, DFG_Len=1 -> 00,01,10,00; Abort on second RUN cycle of DFG_Len=5 group -> IDLE next cycle, no Group_Done.
REQ-034 Reset asserted mid-RUN with Inst_Addr=7 -> next cycle all outputs at reset values; fresh start then drives ROM word 0 first.
REQ-035 DFG_Len=2^ADWIDTH-1, DFG_Num=2 -> Inst_Addr wraps to 0 and continues; sequence completes with one Group_Done.

Source files
------------

// File: rtl/dfg_seq_ctrl.sv
// Group sequencer for DFG execution: steps a push/pop schedule ROM through
// DFG_Num DFGs of DFG_Len cycles each and drives both data-buffer ports.
module dfg_seq_ctrl #(
    parameter int ADWIDTH = 16,
    parameter int CWIDTH  = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Group_Start,
    input  logic               Abort,
    input  logic [CWIDTH-1:0]  DFG_Num,
    input  logic [ADWIDTH-1:0] DFG_Len,
    output logic [ADWIDTH-1:0] Inst_Addr,
    input  logic [3:0]         Inst_Data,
    output logic [1:0]         DBuf0_Status,
    output logic [1:0]         DBuf1_Status,
    output logic               DBuf0_Push,
    output logic               DBuf0_Pop,
    output logic               DBuf1_Push,
    output logic               DBuf1_Pop,
    output logic               Busy,
    output logic               Group_Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_e;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
    localparam logic [1:0] ST_NEXT = 2'b11;

    state_e             state_q,     state_d;
    logic [ADWIDTH-1:0] inst_addr_q, inst_addr_d;
    logic [CWIDTH-1:0]  num_q,       num_d;
    logic [ADWIDTH-1:0] len_q,       len_d;
    logic [CWIDTH-1:0]  dfg_cnt_q,   dfg_cnt_d;
    logic [ADWIDTH-1:0] cyc_cnt_q,   cyc_cnt_d;

    logic start_ok;
    logic last_cyc;
    logic more_dfg;

    assign start_ok = Group_Start && (DFG_Num != '0) && (DFG_Len != '0);
    assign last_cyc = (cyc_cnt_q == len_q - ADWIDTH'(1));
    // Widened by one bit so DFG_Num at its maximum value still compares correctly.
    assign more_dfg = ((CWIDTH+1)'(dfg_cnt_q) + (CWIDTH+1)'(1)) < (CWIDTH+1)'(num_q);

    // NOTE: every register uses <= so all flops update from pre-edge values;
    // the synchronous Reset clears the latched configuration as well.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            inst_addr_q <= '0;
            num_q       <= '0;
            len_q       <= '0;
            dfg_cnt_q   <= '0;
            cyc_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            inst_addr_q <= inst_addr_d;
            num_q       <= num_d;
            len_q       <= len_d;
            dfg_cnt_q   <= dfg_cnt_d;
            cyc_cnt_q   <= cyc_cnt_d;
        end
    end

    // NOTE: state_d gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_ok) state_d = S_LOAD;
            S_LOAD: state_d = S_RUN;
            S_RUN:  if (last_cyc) state_d = more_dfg ? S_NEXT : S_DONE;
            S_NEXT: state_d = S_RUN;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (Abort && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    always_comb begin
        inst_addr_d = inst_addr_q;
        num_d       = num_q;
        len_d       = len_q;
        dfg_cnt_d   = dfg_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;

        if ((state_q == S_IDLE) && start_ok) begin
            num_d       = DFG_Num;
            len_d       = DFG_Len;
            inst_addr_d = '0;
            dfg_cnt_d   = '0;
            cyc_cnt_d   = '0;
        end

        // The ROM answers one cycle late, so the address steps whenever the
        // following cycle is a RUN cycle; it holds across the NEXT gap.
        if (state_d == S_RUN) inst_addr_d = inst_addr_q + ADWIDTH'(1);

        if (state_q == S_RUN) cyc_cnt_d = cyc_cnt_q + ADWIDTH'(1);

        if (state_q == S_NEXT) begin
            dfg_cnt_d = dfg_cnt_q + CWIDTH'(1);
            cyc_cnt_d = '0;
        end
    end

    logic [1:0] status;
    logic [3:0] cmd;

    always_comb begin
        status = ST_IDLE;
        cmd    = '0;
        unique case (state_q)
            S_RUN: begin
                status = ST_RUN;
                cmd    = Inst_Data;
            end
            S_NEXT:  status = ST_NEXT;
            S_DONE:  status = ST_DONE;
            default: status = ST_IDLE;
        endcase
    end

    assign Inst_Addr    = inst_addr_q;
    assign DBuf0_Status = status;
    assign DBuf1_Status = status;
    assign DBuf1_Push   = cmd[3];
    assign DBuf1_Pop    = cmd[2];
    assign DBuf0_Push   = cmd[1];
    assign DBuf0_Pop    = cmd[0];
    assign Busy         = (state_q != S_IDLE);
    assign Group_Done   = (state_q == S_DONE);

endmodule

// File: tb/tb_dfg_seq_ctrl.sv
// Scoreboard bench for dfg_seq_ctrl: directed groups push per-cycle expectations,
// a negedge monitor pops and compares them while Busy is high.
module tb_dfg_seq_ctrl;

    localparam int AW = 8;
    localparam int CW = 8;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Group_Start = 1'b0;
    logic          Abort = 1'b0;
    logic [CW-1:0] DFG_Num = '0;
    logic [AW-1:0] DFG_Len = '0;
    logic [AW-1:0] Inst_Addr;
    logic [3:0]    Inst_Data = '0;
    logic [1:0]    DBuf0_Status, DBuf1_Status;
    logic          DBuf0_Push, DBuf0_Pop, DBuf1_Push, DBuf1_Pop;
    logic          Busy, Group_Done;

    always #5 Clk = ~Clk;

    dfg_seq_ctrl #(.ADWIDTH(AW), .CWIDTH(CW)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Group_Start  (Group_Start),
        .Abort        (Abort),
        .DFG_Num      (DFG_Num),
        .DFG_Len      (DFG_Len),
        .Inst_Addr    (Inst_Addr),
        .Inst_Data    (Inst_Data),
        .DBuf0_Status (DBuf0_Status),
        .DBuf1_Status (DBuf1_Status),
        .DBuf0_Push   (DBuf0_Push),
        .DBuf0_Pop    (DBuf0_Pop),
        .DBuf1_Push   (DBuf1_Push),
        .DBuf1_Pop    (DBuf1_Pop),
        .Busy         (Busy),
        .Group_Done   (Group_Done)
    );

    // Schedule ROM: word k holds k[3:0], registered one cycle behind the address.
    always @(posedge Clk) Inst_Data <= Inst_Addr[3:0];

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] pp;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] st, input int word, input logic done);
        exp_t e;
        e.st   = st;
        e.pp   = 4'(word);
        e.done = done;
        return e;
    endfunction

    // LOAD, then len RUN words per DFG with NEXT between DFGs, then DONE.
    task automatic push_group(input int num, input int len);
        int k = 0;
        exp_q.push_back(mk(2'b00, 0, 1'b0));
        for (int d = 0; d < num; d++) begin
            for (int c = 0; c < len; c++) begin
                exp_q.push_back(mk(2'b01, k, 1'b0));
                k++;
            end
            if (d < num - 1) exp_q.push_back(mk(2'b11, 0, 1'b0));
        end
        exp_q.push_back(mk(2'b10, 0, 1'b1));
    endtask

    // LOAD followed by n_run RUN words, for groups cut short by Abort or Reset.
    task automatic push_partial(input int n_run);
        exp_q.push_back(mk(2'b00, 0, 1'b0));
        for (int k = 0; k < n_run; k++) exp_q.push_back(mk(2'b01, k, 1'b0));
    endtask

    task automatic start(input int num, input int len, input bit ab);
        @(posedge Clk); #1;
        Group_Start = 1'b1;
        DFG_Num     = CW'(num);
        DFG_Len     = AW'(len);
        Abort       = ab;
        @(posedge Clk); #1;
        Group_Start = 1'b0;
        Abort       = 1'b0;
    endtask

    task automatic wait_group(input int bound, input string name, output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge Clk);
            if (Busy !== 1'b1) break;
            busy_cnt++;
        end
        check({name, "_timeout"}, Busy, 0);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    always @(negedge Clk) begin
        if (mon_en) begin
            exp_t e;
            check("status_pair", DBuf1_Status, DBuf0_Status);
            if (Busy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_busy: got status %0h expected idle at %0t", DBuf0_Status, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("status", DBuf0_Status, e.st);
                    check("pushpop", {DBuf1_Push, DBuf1_Pop, DBuf0_Push, DBuf0_Pop}, e.pp);
                    check("group_done", Group_Done, e.done);
                end
            end else begin
                check("idle_busy", Busy, 0);
                check("idle_status", DBuf0_Status, 0);
                check("idle_pushpop", {DBuf1_Push, DBuf1_Pop, DBuf0_Push, DBuf0_Pop}, 0);
                check("idle_done", Group_Done, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;

        repeat (3) @(posedge Clk);
        #1;
        check("reset_busy", Busy, 0);
        check("reset_addr", Inst_Addr, 0);
        check("reset_status", DBuf0_Status, 0);
        check("reset_done", Group_Done, 0);
        Reset  = 1'b0;
        mon_en = 1'b1;

        // Two DFGs of three cycles.
        push_group(2, 3);
        start(2, 3, 1'b0);
        wait_group(50, "g2x3", cnt);
        check("g2x3_busy_cycles", cnt, 9);

        // Zero count or zero length is ignored.
        start(0, 3, 1'b0);
        wait_group(4, "num0", cnt);
        check("num0_busy_cycles", cnt, 0);
        repeat (3) @(posedge Clk);
        start(2, 0, 1'b0);
        wait_group(4, "len0", cnt);
        check("len0_busy_cycles", cnt, 0);
        repeat (3) @(posedge Clk);

        // Shortest group.
        push_group(1, 1);
        start(1, 1, 1'b0);
        wait_group(20, "g1x1", cnt);
        check("g1x1_busy_cycles", cnt, 3);

        // A second start and changed config during RUN leave the group unchanged.
        push_group(2, 3);
        start(2, 3, 1'b0);
        @(posedge Clk); #1;
        Group_Start = 1'b1;
        DFG_Num     = 8'd5;
        DFG_Len     = 8'd7;
        @(posedge Clk); #1;
        Group_Start = 1'b0;
        wait_group(50, "restart", cnt);

        // Abort on the second RUN cycle of a five-cycle DFG.
        push_partial(2);
        start(1, 5, 1'b0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Abort = 1'b1;
        @(posedge Clk); #1;
        Abort = 1'b0;
        check("abort_busy", Busy, 0);
        check("abort_done", Group_Done, 0);
        wait_group(10, "abort", cnt);

        // Abort held in IDLE does not block a start.
        push_group(1, 2);
        start(1, 2, 1'b1);
        wait_group(20, "abort_idle", cnt);

        // Reset mid-RUN at address 7 overrides Abort and Group_Start.
        push_partial(7);
        start(1, 10, 1'b0);
        repeat (7) begin
            @(posedge Clk); #1;
        end
        check("addr_before_reset", Inst_Addr, 7);
        Reset       = 1'b1;
        Abort       = 1'b1;
        Group_Start = 1'b1;
        @(posedge Clk); #1;
        Reset       = 1'b0;
        Abort       = 1'b0;
        Group_Start = 1'b0;
        check("rst_mid_addr", Inst_Addr, 0);
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_status", DBuf1_Status, 0);
        check("rst_mid_pushpop", {DBuf1_Push, DBuf1_Pop, DBuf0_Push, DBuf0_Pop}, 0);
        check("rst_mid_done", Group_Done, 0);
        wait_group(5, "rst_mid", cnt);
        push_group(1, 2);
        start(1, 2, 1'b0);
        wait_group(20, "post_reset", cnt);
        check("post_reset_busy_cycles", cnt, 4);

        // Maximum length forces Inst_Addr through its wrap.
        push_group(2, 255);
        start(2, 255, 1'b0);
        wait_group(700, "wrap", cnt);
        check("wrap_busy_cycles", cnt, 513);

        repeat (2) @(posedge Clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
